// File: rtl/exe_mem_stage_reg.sv
// EXE->MEM boundary: small FIFO toward MEM plus the {Z,C,N,V} status register.
// Define STATUS_BYPASS_EN to forward freshly written flags combinationally.
module exe_mem_stage_reg #(
  parameter int REGISTER_LEN = 32,
  parameter int DEST_LEN     = 4,
  parameter int DEPTH        = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      flush,
  input  logic [REGISTER_LEN-1:0]   alu_out,
  input  logic [3:0]                alu_status,
  input  logic                      s_bit,
  input  logic [REGISTER_LEN-1:0]   val_rm,
  input  logic [DEST_LEN-1:0]       dest,
  input  logic                      wb_en,
  input  logic                      mem_r_en,
  input  logic                      mem_w_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REGISTER_LEN-1:0]   out_alu,
  output logic [REGISTER_LEN-1:0]   out_val_rm,
  output logic [DEST_LEN-1:0]       out_dest,
  output logic                      out_wb_en,
  output logic                      out_mem_r_en,
  output logic                      out_mem_w_en,
  output logic [3:0]                status_reg,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [REGISTER_LEN-1:0] alu;
    logic [REGISTER_LEN-1:0] val_rm;
    logic [DEST_LEN-1:0]     dest;
    logic                    wb_en;
    logic                    mem_r_en;
    logic                    mem_w_en;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  entry_t          last_q, last_d;
  entry_t          head, in_ent;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic [3:0]      status_q, status_d;
  logic            accept, pop;

  assign accept = in_valid & in_ready_q & ~flush;
  assign pop    = out_valid & out_ready;

  always_comb begin
    in_ent          = '0;
    in_ent.alu      = alu_out;
    in_ent.val_rm   = val_rm;
    in_ent.dest     = dest;
    in_ent.wb_en    = wb_en;
    in_ent.mem_r_en = mem_r_en;
    in_ent.mem_w_en = mem_w_en;
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    last_d     = last_q;
    status_d   = status_q;
    if (accept) begin
      mem_d[wr_ptr_q] = in_ent;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    // Remember the popped head so outputs hold it while empty.
    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (accept && s_bit)
      status_d = alu_status;
    count_d    = count_q + CW'(accept) - CW'(pop);
    in_ready_d = count_d < CW'(DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      status_q   <= '0;
      last_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      status_q   <= status_d;
      last_q     <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      mem_q <= mem_d;
  end

  assign head = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;

  assign in_ready     = in_ready_q;
  assign out_valid    = count_q != '0;
  assign out_alu      = head.alu;
  assign out_val_rm   = head.val_rm;
  assign out_dest     = head.dest;
  assign out_wb_en    = head.wb_en;
  assign out_mem_r_en = head.mem_r_en;
  assign out_mem_w_en = head.mem_w_en;
  assign count        = count_q;

`ifdef STATUS_BYPASS_EN
  assign status_reg = (accept && s_bit) ? alu_status : status_q;
`else
  assign status_reg = status_q;
`endif

endmodule
